// File: rtl/z480_lsu_issue.sv
// z480_lsu_issue
//   In-order load/store issue stage between execute and the dcache_port.
//   An accepted op is held in a one-entry skid register (S). From S it either
//   issues an aligned request to the cache or, if misaligned, completes locally
//   as a fault. Per-op metadata rides in a small tracking FIFO (T) until the
//   cache answers (in issue order). The answer is then lane-shifted and
//   extended into a one-entry result register (R) for writeback.
//
// Ports
//   clk, rst_n                       core clock, async active-low reset
//   in_valid/in_ready                op handshake from execute
//   in_write, in_size, in_signed     op kind, access size (log2 bytes), load sign-extend
//   in_addr, in_wdata, in_tag        byte address, right-justified store data, wb tag
//   req_valid/req_ready              request handshake to dcache_port
//   req_write, req_addr              op kind, dword-aligned address
//   req_wdata, req_wstrb             lane-shifted store data and byte strobes
//   rsp_valid/rsp_ready              response handshake from dcache_port
//   rsp_rdata, rsp_fault             response dword and fault flag
//   res_valid/res_ready              result handshake to writeback
//   res_tag, res_data                tag and extended load data (0 for stores/faults)
//   res_fault, res_misalign          any fault, and whether it was a local misalign

module z480_lsu_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_write,
  input  logic [1:0]       in_size,
  input  logic             in_signed,
  input  logic [63:0]      in_addr,
  input  logic [63:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_write,
  output logic [63:0]      req_addr,
  output logic [63:0]      req_wdata,
  output logic [7:0]       req_wstrb,
  input  logic             rsp_valid,
  input  logic [63:0]      rsp_rdata,
  input  logic             rsp_fault,
  output logic             rsp_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [63:0]      res_data,
  output logic             res_fault,
  output logic             res_misalign
);

  localparam int AW = $clog2(DEPTH);
  // T entry: {tag, size, signed, offset, write, misalign}
  localparam int EW = TAG_W + 8;

  // ---------------------------------------------------------------- S
  logic             s_v;
  logic             s_write;
  logic [1:0]       s_size;
  logic             s_signed;
  logic [63:0]      s_addr;
  logic [63:0]      s_wdata;
  logic [TAG_W-1:0] s_tag;

  logic [2:0] s_off;
  logic [2:0] s_size_mask;
  logic [7:0] s_strb_base;
  logic       s_mis;
  logic       s_leave;
  logic       s_bypass;
  logic       in_fire;

  // ---------------------------------------------------------------- T
  logic [EW-1:0] t_mem [DEPTH];
  logic [AW:0]   t_wr_ptr;
  logic [AW:0]   t_rd_ptr;
  logic          t_empty;
  logic          t_full;
  logic          t_push;
  logic          t_pop;
  logic [EW-1:0] t_head;
  logic [TAG_W-1:0] h_tag;
  logic [1:0]    h_size;
  logic          h_signed;
  logic [2:0]    h_off;
  logic          h_write;
  logic          h_mis;
  logic          h_mis_done;
  logic          rsp_fire;

  // ---------------------------------------------------------------- R
  logic             r_v;
  logic [TAG_W-1:0] r_tag;
  logic [63:0]      r_data;
  logic             r_fault;
  logic             r_mis;
  logic             r_accept;
  logic [63:0]      rsp_lane;
  logic [63:0]      rsp_ext;

  // Size-dependent masks for the op sitting in S.
  assign s_off = s_addr[2:0];
  always_comb begin
    s_size_mask = 3'b111;
    s_strb_base = 8'hFF;
    case (s_size)
      2'd0:    begin s_size_mask = 3'b000; s_strb_base = 8'h01; end
      2'd1:    begin s_size_mask = 3'b001; s_strb_base = 8'h03; end
      2'd2:    begin s_size_mask = 3'b011; s_strb_base = 8'h0F; end
      default: begin s_size_mask = 3'b111; s_strb_base = 8'hFF; end
    endcase
  end
  assign s_mis = |(s_off & s_size_mask);

  assign t_empty  = (t_wr_ptr == t_rd_ptr);
  assign t_full   = (t_wr_ptr[AW] != t_rd_ptr[AW]) &&
                    (t_wr_ptr[AW-1:0] == t_rd_ptr[AW-1:0]);
  assign r_accept = !r_v || res_ready;

  // A misaligned op with nothing older outstanding skips T and goes straight
  // into R; this gives the two-cycle accept-to-result latency for local faults
  // and cannot reorder results because T is empty.
  assign s_bypass = s_v && s_mis && t_empty && r_accept;
  assign s_leave  = s_v && !t_full && (s_mis || req_ready);
  assign t_push   = s_leave && !s_bypass;
  assign in_ready = !s_v || s_leave;
  assign in_fire  = in_valid && in_ready;

  // Request formatting straight from S.
  assign req_valid = s_v && !t_full && !s_mis;
  assign req_write = s_write;
  assign req_addr  = {s_addr[63:3], 3'b000};
  assign req_wdata = s_write ? (s_wdata << {s_off, 3'b000}) : 64'd0;
  assign req_wstrb = s_write ? (s_strb_base << s_off) : 8'd0;

  // T head decode (asynchronous read so rsp_ready is available this cycle).
  assign t_head = t_mem[t_rd_ptr[AW-1:0]];
  assign {h_tag, h_size, h_signed, h_off, h_write, h_mis} = t_head;

  assign rsp_ready  = !t_empty && !h_mis && r_accept;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign h_mis_done = !t_empty && h_mis && r_accept;
  assign t_pop      = h_mis_done || rsp_fire;

  // Response lane extraction and extension.
  assign rsp_lane = rsp_rdata >> {h_off, 3'b000};
  always_comb begin
    rsp_ext = rsp_lane;
    case (h_size)
      2'd0:    rsp_ext = {{56{h_signed & rsp_lane[7]}},  rsp_lane[7:0]};
      2'd1:    rsp_ext = {{48{h_signed & rsp_lane[15]}}, rsp_lane[15:0]};
      2'd2:    rsp_ext = {{32{h_signed & rsp_lane[31]}}, rsp_lane[31:0]};
      default: rsp_ext = rsp_lane;
    endcase
  end

  // ---------------------------------------------------------------- S state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_v      <= 1'b0;
      s_write  <= 1'b0;
      s_size   <= 2'd0;
      s_signed <= 1'b0;
      s_addr   <= 64'd0;
      s_wdata  <= 64'd0;
      s_tag    <= '0;
    end else if (in_fire) begin
      s_v      <= 1'b1;
      s_write  <= in_write;
      s_size   <= in_size;
      s_signed <= in_signed;
      s_addr   <= in_addr;
      s_wdata  <= in_wdata;
      s_tag    <= in_tag;
    end else if (s_leave) begin
      s_v      <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- T state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_wr_ptr <= '0;
      t_rd_ptr <= '0;
    end else begin
      if (t_push) t_wr_ptr <= t_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (t_pop)  t_rd_ptr <= t_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (t_push) t_mem[t_wr_ptr[AW-1:0]] <= {s_tag, s_size, s_signed, s_off, s_write, s_mis};
  end

  // ---------------------------------------------------------------- R state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= 1'b0;
      r_tag   <= '0;
      r_data  <= 64'd0;
      r_fault <= 1'b0;
      r_mis   <= 1'b0;
    end else if (s_bypass) begin
      r_v     <= 1'b1;
      r_tag   <= s_tag;
      r_data  <= 64'd0;
      r_fault <= 1'b1;
      r_mis   <= 1'b1;
    end else if (h_mis_done) begin
      r_v     <= 1'b1;
      r_tag   <= h_tag;
      r_data  <= 64'd0;
      r_fault <= 1'b1;
      r_mis   <= 1'b1;
    end else if (rsp_fire) begin
      r_v     <= 1'b1;
      r_tag   <= h_tag;
      r_data  <= (rsp_fault || h_write) ? 64'd0 : rsp_ext;
      r_fault <= rsp_fault;
      r_mis   <= 1'b0;
    end else if (res_ready) begin
      r_v     <= 1'b0;
    end
  end

  assign res_valid    = r_v;
  assign res_tag      = r_tag;
  assign res_data     = r_data;
  assign res_fault    = r_fault;
  assign res_misalign = r_mis;

`ifndef SYNTHESIS
  // The cache may only answer when an aligned op is waiting at the head of T.
  rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> (!t_empty && !h_mis));
`endif

endmodule

// File: tb/tb_z480_lsu_issue.sv
// Directed bench for z480_lsu_issue with a small in-order cache model and
// scoreboards for requests and results.
module tb_z480_lsu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_write = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic        in_signed = 1'b0;
  logic [63:0] in_addr = 64'd0;
  logic [63:0] in_wdata = 64'd0;
  logic [5:0]  in_tag = 6'd0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp_rdata = 64'd0;
  logic        rsp_fault = 1'b0;
  logic        rsp_ready;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [5:0]  res_tag;
  logic [63:0] res_data;
  logic        res_fault;
  logic        res_misalign;

  z480_lsu_issue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
    .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_tag(in_tag),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_ready(rsp_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .res_fault(res_fault), .res_misalign(res_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        write;
  } req_t;
  typedef struct {
    logic [5:0]  tag;
    logic [63:0] data;
    logic        fault;
    logic        mis;
  } res_t;
  typedef struct {
    logic [63:0] rdata;
    logic        fault;
  } plan_t;

  req_t  exp_req_q[$];
  res_t  exp_res_q[$];
  plan_t plan_q[$];
  int    pend = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Monitor: values are stable from the falling edge to the next rising edge,
  // so a handshake seen here is the one that completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_req_q.delete();
      exp_res_q.delete();
      plan_q.delete();
      pend = 0;
    end else begin
      if (req_valid && req_ready) begin
        check("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
        if (exp_req_q.size() != 0) begin
          req_t e;
          e = exp_req_q.pop_front();
          $display("req addr=%h wdata=%h wstrb=%h write=%b", req_addr, req_wdata, req_wstrb, req_write);
          check("req_addr",  req_addr,  e.addr);
          check("req_wdata", req_wdata, e.wdata);
          check("req_wstrb", 64'(req_wstrb), 64'(e.wstrb));
          check("req_write", 64'(req_write), 64'(e.write));
        end
        pend++;
      end
      if (rsp_valid && rsp_ready) begin
        pend--;
        void'(plan_q.pop_front());
      end
      if (res_valid && res_ready) begin
        check("res_expected", 64'(exp_res_q.size() != 0), 64'd1);
        if (exp_res_q.size() != 0) begin
          res_t e;
          e = exp_res_q.pop_front();
          $display("res tag=%h data=%h fault=%b misalign=%b", res_tag, res_data, res_fault, res_misalign);
          check("res_tag",      64'(res_tag),      64'(e.tag));
          check("res_data",     res_data,          e.data);
          check("res_fault",    64'(res_fault),    64'(e.fault));
          check("res_misalign", 64'(res_misalign), 64'(e.mis));
        end
      end
    end
  end

  // In-order cache model: answers each issued request with the planned response.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && pend > 0 && plan_q.size() != 0) begin
        rsp_valid = 1'b1;
        rsp_rdata = plan_q[0].rdata;
        rsp_fault = plan_q[0].fault;
      end else begin
        rsp_valid = 1'b0;
        rsp_rdata = 64'd0;
        rsp_fault = 1'b0;
      end
    end
  end

  // Called at rising edge + 1; returns one cycle after the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [5:0] tg);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_write = wr; in_size = sz; in_signed = sg;
    in_addr = addr; in_wdata = wd; in_tag = tg;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("issue_accepted", 64'(ok), 64'd1);
  endtask

  task automatic op_load(input logic [1:0] sz, input logic sg, input logic [63:0] addr,
                         input logic [5:0] tg, input logic [63:0] rdata, input logic flt,
                         input logic [63:0] exp_data);
    exp_req_q.push_back('{addr: {addr[63:3], 3'b000}, wdata: 64'd0, wstrb: 8'h00, write: 1'b0});
    plan_q.push_back('{rdata: rdata, fault: flt});
    exp_res_q.push_back('{tag: tg, data: exp_data, fault: flt, mis: 1'b0});
    issue(1'b0, sz, sg, addr, 64'd0, tg);
  endtask

  task automatic op_store(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [5:0] tg, input logic [63:0] exp_wd, input logic [7:0] exp_strb);
    exp_req_q.push_back('{addr: {addr[63:3], 3'b000}, wdata: exp_wd, wstrb: exp_strb, write: 1'b1});
    plan_q.push_back('{rdata: 64'hDEAD_BEEF_DEAD_BEEF, fault: 1'b0});
    exp_res_q.push_back('{tag: tg, data: 64'd0, fault: 1'b0, mis: 1'b0});
    issue(1'b1, sz, 1'b0, addr, wd, tg);
  endtask

  task automatic op_mis(input logic wr, input logic [1:0] sz, input logic [63:0] addr, input logic [5:0] tg);
    exp_res_q.push_back('{tag: tg, data: 64'd0, fault: 1'b1, mis: 1'b1});
    issue(wr, sz, 1'b1, addr, 64'h55, tg);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_res_q.size() != 0 && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_remaining", 64'(exp_res_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_addr",  req_addr,       64'd0);
    check("rst_req_wdata", req_wdata,      64'd0);
    check("rst_req_wstrb", 64'(req_wstrb), 64'd0);
    check("rst_res_tag",   64'(res_tag),   64'd0);
    check("rst_res_data",  res_data,       64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed byte load with latency checks
    op_load(2'd0, 1'b1, 64'h1003, 6'h01, 64'h0000_0000_8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    check("lat_req_valid_next", 64'(req_valid), 64'd1);
    check("lat_req_addr", req_addr, 64'h1000);
    @(posedge clk); #1;
    check("lat_rsp_ready", 64'(rsp_ready), 64'd1);
    check("lat_res_not_yet", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_res_valid", 64'(res_valid), 64'd1);
    wait_drain();

    // Half store into the top lanes
    op_store(2'd1, 64'h2006, 64'h1234, 6'h02, 64'h1234_0000_0000_0000, 8'hC0);
    wait_drain();

    // Misaligned word load: no request, fault two cycles after accept
    op_mis(1'b0, 2'd2, 64'h3002, 6'h03);
    check("mis_no_req", 64'(req_valid), 64'd0);
    check("mis_res_not_yet", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    check("mis_res_valid", 64'(res_valid), 64'd1);
    check("mis_no_req2", 64'(req_valid), 64'd0);
    wait_drain();

    // Dword load fault from the cache
    op_load(2'd3, 1'b1, 64'h4000, 6'h2A, 64'h0123_4567_89AB_CDEF, 1'b1, 64'd0);
    wait_drain();

    // More lane / extension / strobe patterns
    op_load(2'd1, 1'b0, 64'h5002, 6'h05, 64'h0000_0000_ABCD_0000, 1'b0, 64'h0000_0000_0000_ABCD);
    op_load(2'd2, 1'b1, 64'h6004, 6'h06, 64'h8765_4321_0000_0000, 1'b0, 64'hFFFF_FFFF_8765_4321);
    op_store(2'd3, 64'h7000, 64'hCAFE_F00D_1234_5678, 6'h07, 64'hCAFE_F00D_1234_5678, 8'hFF);
    op_store(2'd2, 64'h7004, 64'hDEAD_BEEF, 6'h08, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    op_mis(1'b1, 2'd3, 64'h7F04, 6'h09);
    wait_drain();

    // Request backpressure: req_valid holds until the cache takes it
    req_ready = 1'b0;
    op_load(2'd0, 1'b0, 64'h9005, 6'h0A, 64'h0000_AB00_0000_0000, 1'b0, 64'h0000_0000_0000_00AB);
    check("req_hold_1", 64'(req_valid), 64'd1);
    @(posedge clk); #1;
    check("req_hold_2", 64'(req_valid), 64'd1);
    req_ready = 1'b1;
    wait_drain();

    // Eight back-to-back loads against a stalled writeback
    res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          op_load(2'd3, 1'b0, 64'h8000 + 64'(8 * i), 6'(16 + i),
                  64'h1111_0000_0000_0000 + 64'(i), 1'b0, 64'h1111_0000_0000_0000 + 64'(i));
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        check("full_in_ready_low", 64'(in_ready), 64'd0);
        check("full_res_held", 64'(res_valid), 64'd1);
        check("full_res_tag", 64'(res_tag), 64'd16);
        res_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three ops in flight
    res_ready = 1'b0;
    op_load(2'd3, 1'b0, 64'hA000, 6'h31, 64'h1, 1'b0, 64'h1);
    op_load(2'd3, 1'b0, 64'hA008, 6'h32, 64'h2, 1'b0, 64'h2);
    op_load(2'd3, 1'b0, 64'hA010, 6'h33, 64'h3, 1'b0, 64'h3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_req_valid", 64'(req_valid), 64'd0);
    check("mid_rst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    op_load(2'd2, 1'b0, 64'hB004, 6'h3C, 64'hF000_0001_0000_0000, 1'b0, 64'h0000_0000_F000_0001);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
